// File: rtl/mips_cpu_pkg.sv
// -----------------------------------------------------------------------------
// mips_cpu_pkg
// Shared definitions for the MIPS store path: the store opcode encodings and
// the store-buffer entry layout {address, writedata, byteenable}.
// -----------------------------------------------------------------------------
package mips_cpu_pkg;

  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SWL = 6'b101010;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SWR = 6'b101110;

  typedef struct packed {
    logic [31:0] address;     // word aligned, bits [1:0] = 00
    logic [31:0] writedata;   // lane-aligned data
    logic [3:0]  byteenable;  // bit k enables writedata[8k+7:8k]
  } store_entry_t;

endpackage

// File: rtl/mips_cpu_store_unit_if.sv
// -----------------------------------------------------------------------------
// mips_cpu_store_unit_if
// Groups the store-request handshake and the Avalon-style write bus of the
// store unit.
//   Request : req_valid, req_ready, req_opcode[5:0], req_addr[31:0],
//             req_data[31:0], store_err
//   Bus     : write, address[31:0], writedata[31:0], byteenable[3:0],
//             waitrequest
//   Status  : busy
// Modports:
//   slave  - the store unit (consumes requests, drives the bus)
//   master - the environment (issues requests, models the memory)
// -----------------------------------------------------------------------------
interface mips_cpu_store_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_opcode;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        write;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic        busy;
  logic        store_err;

  modport slave (
    input  req_valid, req_opcode, req_addr, req_data, waitrequest,
    output req_ready, write, address, writedata, byteenable, busy, store_err
  );

  modport master (
    output req_valid, req_opcode, req_addr, req_data, waitrequest,
    input  req_ready, write, address, writedata, byteenable, busy, store_err
  );

endinterface

// File: rtl/mips_cpu_store_align.sv
// -----------------------------------------------------------------------------
// mips_cpu_store_align
// Combinational lane alignment for MIPS stores (little-endian: byte offset k
// maps to lane k). Produces lane-aligned write data, byte enables and a reject
// flag for misaligned accesses or unsupported opcodes.
// Configuration macro: MIPS_CPU_STORE_UNALIGNED_EN enables swl/swr; without it
// both are rejected.
// Ports:
//   i_opcode[5:0]     store opcode
//   i_offset[1:0]     byte offset within the word (req_addr[1:0])
//   i_data[31:0]      rt register value
//   o_writedata[31:0] lane-aligned data (0 when rejected)
//   o_byteenable[3:0] active lanes (0 when rejected)
//   o_reject          request must not be enqueued
// -----------------------------------------------------------------------------
module mips_cpu_store_align
  import mips_cpu_pkg::*;
(
  input  logic [5:0]  i_opcode,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_data,
  output logic [31:0] o_writedata,
  output logic [3:0]  o_byteenable,
  output logic        o_reject
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    o_writedata  = '0;
    o_byteenable = '0;
    o_reject     = 1'b0;
    case (i_opcode)
      OP_SB: begin
        o_writedata  = {4{i_data[7:0]}};
        o_byteenable = 4'b0001 << i_offset;
      end
      OP_SH: begin
        if (i_offset[0]) begin
          o_reject = 1'b1;
        end else begin
          o_writedata  = {2{i_data[15:0]}};
          o_byteenable = i_offset[1] ? 4'b1100 : 4'b0011;
        end
      end
      OP_SW: begin
        if (i_offset != 2'd0) begin
          o_reject = 1'b1;
        end else begin
          o_writedata  = i_data;
          o_byteenable = 4'b1111;
        end
      end
`ifdef MIPS_CPU_STORE_UNALIGNED_EN
      // swl writes the most-significant bytes of rt into lanes 0..k.
      OP_SWL: begin
        o_writedata  = i_data >> {2'd3 - i_offset, 3'b000};
        o_byteenable = 4'b1111 >> (2'd3 - i_offset);
      end
      // swr writes the least-significant bytes of rt into lanes k..3.
      OP_SWR: begin
        o_writedata  = i_data << {i_offset, 3'b000};
        o_byteenable = 4'b1111 << i_offset;
      end
`endif
      default: o_reject = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_cpu_store_unit.sv
// -----------------------------------------------------------------------------
// mips_cpu_store_unit
// Store buffer between the MIPS pipeline and an Avalon-style write bus.
// Accepted, well-formed stores are lane-aligned and queued in a DEPTH-entry
// FIFO; the head entry drives the bus until the memory accepts it
// (write && !waitrequest). Rejected requests pulse store_err for one cycle.
// Configuration macro: MIPS_CPU_STORE_UNALIGNED_EN (swl/swr support, handled
// in mips_cpu_store_align).
// Parameters:
//   DEPTH  store-buffer entries; must be a power of two, at least 2
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      mips_cpu_store_unit_if.slave (request handshake + write bus)
// -----------------------------------------------------------------------------
module mips_cpu_store_unit
  import mips_cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic                  clk,
  input logic                  reset_n,
  mips_cpu_store_unit_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  store_entry_t r_mem [DEPTH];
  logic         r_store_err;

  logic [31:0]  w_align_data;
  logic [3:0]   w_align_be;
  logic         w_reject;
  logic         w_empty;
  logic         w_full;
  logic         w_ready;
  logic         w_accept;
  logic         w_push;
  logic         w_pop;
  store_entry_t w_head;
  store_entry_t w_new_entry;

  mips_cpu_store_align u_align (
    .i_opcode     (bus.req_opcode),
    .i_offset     (bus.req_addr[1:0]),
    .i_data       (bus.req_data),
    .o_writedata  (w_align_data),
    .o_byteenable (w_align_be),
    .o_reject     (w_reject)
  );

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // Ready depends only on fullness, never on a same-cycle pop.
  assign w_ready  = reset_n && !w_full;
  assign w_accept = bus.req_valid && w_ready;
  assign w_push   = w_accept && !w_reject;
  assign w_pop    = !w_empty && !bus.waitrequest;

  assign w_new_entry = '{address:    {bus.req_addr[31:2], 2'b00},
                         writedata:  w_align_data,
                         byteenable: w_align_be};
  assign w_head      = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every block sees
    // the pre-edge values regardless of evaluation order.
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_store_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_store_err <= w_accept && w_reject;
    end
  end

  // NOTE: the entry storage is deliberately not reset; emptiness is defined by
  // the pointers, and the bus outputs are gated while the buffer is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_new_entry;
  end

  assign bus.req_ready  = w_ready;
  assign bus.write      = !w_empty;
  assign bus.busy       = !w_empty;
  assign bus.store_err  = r_store_err;
  assign bus.address    = w_empty ? 32'd0 : w_head.address;
  assign bus.writedata  = w_empty ? 32'd0 : w_head.writedata;
  assign bus.byteenable = w_empty ? 4'd0  : w_head.byteenable;

endmodule

// File: tb/tb_mips_cpu_store_unit.sv
// -----------------------------------------------------------------------------
// tb_mips_cpu_store_unit
// Directed bench for mips_cpu_store_unit (DEPTH = 2). Inputs are driven and
// outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mips_cpu_store_unit;
  import mips_cpu_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mips_cpu_store_unit_if bus_if ();

  mips_cpu_store_unit #(.DEPTH(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data);
    bus_if.req_valid  = 1'b1;
    bus_if.req_opcode = op;
    bus_if.req_addr   = addr;
    bus_if.req_data   = data;
  endtask

  task automatic expect_bus(input string tag, input logic w, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be);
    check({tag, ".write"},      32'(bus_if.write), 32'(w));
    check({tag, ".address"},    bus_if.address, a);
    check({tag, ".writedata"},  bus_if.writedata, wd);
    check({tag, ".byteenable"}, 32'(bus_if.byteenable), 32'(be));
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
  } bad_req_t;

  bad_req_t bad_reqs [3] = '{'{OP_SW, 32'h0000_3001},
                             '{OP_SH, 32'h0000_2001},
                             '{6'b100011, 32'h0000_0000}};

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n            = 1'b0;
    bus_if.req_valid   = 1'b0;
    bus_if.req_opcode  = '0;
    bus_if.req_addr    = '0;
    bus_if.req_data    = '0;
    bus_if.waitrequest = 1'b0;

    // Reset state
    step(); step();
    check("rst.req_ready", 32'(bus_if.req_ready), 32'd0);
    check("rst.busy", 32'(bus_if.busy), 32'd0);
    check("rst.store_err", 32'(bus_if.store_err), 32'd0);
    expect_bus("rst", 1'b0, 32'd0, 32'd0, 4'd0);
    reset_n = 1'b1;
    step();
    check("post_rst.req_ready", 32'(bus_if.req_ready), 32'd1);

    // sb 0x1003, no stall: one bus cycle then idle
    drive(OP_SB, 32'h0000_1003, 32'h0000_00AB);
    step();
    bus_if.req_valid = 1'b0;
    expect_bus("sb", 1'b1, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000);
    check("sb.store_err", 32'(bus_if.store_err), 32'd0);
    step();
    expect_bus("sb_done", 1'b0, 32'd0, 32'd0, 4'd0);
    check("sb_done.busy", 32'(bus_if.busy), 32'd0);

    // sb at every lane of 0x7000
    for (int k = 0; k < 4; k++) begin
      drive(OP_SB, 32'h0000_7000 + 32'(k), 32'h1234_565A);
      step();
      bus_if.req_valid = 1'b0;
      expect_bus($sformatf("sb_lane%0d", k), 1'b1, 32'h0000_7000, 32'h5A5A_5A5A, 4'b0001 << k);
      step();
    end

    // sh 0x2002 with waitrequest high for 3 cycles: held 4 cycles, one pop
    bus_if.waitrequest = 1'b1;
    drive(OP_SH, 32'h0000_2002, 32'h0000_1234);
    step();
    bus_if.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_bus($sformatf("sh_stall%0d", i), 1'b1, 32'h0000_2000, 32'h1234_1234, 4'b1100);
      step();
    end
    bus_if.waitrequest = 1'b0;
    expect_bus("sh_release", 1'b1, 32'h0000_2000, 32'h1234_1234, 4'b1100);
    step();
    expect_bus("sh_done", 1'b0, 32'd0, 32'd0, 4'd0);
    check("sh_done.busy", 32'(bus_if.busy), 32'd0);

    // Rejected requests: misaligned sw, odd sh, non-store opcode
    for (int i = 0; i < 3; i++) begin
      drive(bad_reqs[i].op, bad_reqs[i].addr, 32'hCAFE_F00D);
      step();
      bus_if.req_valid = 1'b0;
      check($sformatf("bad%0d.store_err", i), 32'(bus_if.store_err), 32'd1);
      check($sformatf("bad%0d.write", i), 32'(bus_if.write), 32'd0);
      check($sformatf("bad%0d.busy", i), 32'(bus_if.busy), 32'd0);
      step();
      check($sformatf("bad%0d.err_clear", i), 32'(bus_if.store_err), 32'd0);
      check($sformatf("bad%0d.write_after", i), 32'(bus_if.write), 32'd0);
    end

    // Three back-to-back sw into a 2-entry buffer while stalled
    bus_if.waitrequest = 1'b1;
    drive(OP_SW, 32'h0000_5000, 32'h1111_1111);
    check("bp.ready0", 32'(bus_if.req_ready), 32'd1);
    step();
    drive(OP_SW, 32'h0000_5004, 32'h2222_2222);
    check("bp.ready1", 32'(bus_if.req_ready), 32'd1);
    step();
    drive(OP_SW, 32'h0000_5008, 32'h3333_3333);
    check("bp.full_ready", 32'(bus_if.req_ready), 32'd0);
    step();
    check("bp.still_full", 32'(bus_if.req_ready), 32'd0);
    expect_bus("bp.head0", 1'b1, 32'h0000_5000, 32'h1111_1111, 4'b1111);
    bus_if.waitrequest = 1'b0;
    step();
    // First entry popped; third request is accepted at the next edge
    expect_bus("bp.head1", 1'b1, 32'h0000_5004, 32'h2222_2222, 4'b1111);
    check("bp.ready_after_pop", 32'(bus_if.req_ready), 32'd1);
    step();
    bus_if.req_valid = 1'b0;
    expect_bus("bp.head2", 1'b1, 32'h0000_5008, 32'h3333_3333, 4'b1111);
    step();
    expect_bus("bp.done", 1'b0, 32'd0, 32'd0, 4'd0);
    check("bp.busy", 32'(bus_if.busy), 32'd0);

    // swl / swr at 0x4001
    drive(OP_SWL, 32'h0000_4001, 32'hAABB_CCDD);
    step();
    bus_if.req_valid = 1'b0;
`ifdef MIPS_CPU_STORE_UNALIGNED_EN
    expect_bus("swl", 1'b1, 32'h0000_4000, 32'h0000_AABB, 4'b0011);
    check("swl.store_err", 32'(bus_if.store_err), 32'd0);
`else
    check("swl.store_err", 32'(bus_if.store_err), 32'd1);
    check("swl.write", 32'(bus_if.write), 32'd0);
`endif
    step();
    drive(OP_SWR, 32'h0000_4001, 32'hAABB_CCDD);
    step();
    bus_if.req_valid = 1'b0;
`ifdef MIPS_CPU_STORE_UNALIGNED_EN
    expect_bus("swr", 1'b1, 32'h0000_4000, 32'hBBCC_DD00, 4'b1110);
    check("swr.store_err", 32'(bus_if.store_err), 32'd0);
`else
    check("swr.store_err", 32'(bus_if.store_err), 32'd1);
    check("swr.write", 32'(bus_if.write), 32'd0);
`endif
    step();
    check("swlr.idle", 32'(bus_if.busy), 32'd0);

    // Reset during a stalled write abandons the entry
    bus_if.waitrequest = 1'b1;
    drive(OP_SW, 32'h0000_6000, 32'hDEAD_BEEF);
    step();
    bus_if.req_valid = 1'b0;
    expect_bus("rst_stall.pre", 1'b1, 32'h0000_6000, 32'hDEAD_BEEF, 4'b1111);
    reset_n = 1'b0;
    step();
    check("rst_stall.ready_in_rst", 32'(bus_if.req_ready), 32'd0);
    reset_n = 1'b1;
    expect_bus("rst_stall.post", 1'b0, 32'd0, 32'd0, 4'd0);
    check("rst_stall.busy", 32'(bus_if.busy), 32'd0);
    step();
    bus_if.waitrequest = 1'b0;
    step();
    expect_bus("rst_stall.gone", 1'b0, 32'd0, 32'd0, 4'd0);
    check("rst_stall.busy_gone", 32'(bus_if.busy), 32'd0);
    check("rst_stall.ready", 32'(bus_if.req_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
